// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store traffic. Data normally has priority; a burst counter bounds how
// many data grants may pass a waiting fetch. A redirect (flush) drops the
// result of an in-flight fetch without disturbing the memory handshake.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  // load/store requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  // pipeline control
  input  logic        pause,
  input  logic        flush,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // stalls back to the pipeline
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int unsigned BW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   burst_cnt_q;
  logic [BW-1:0]   burst_cnt_d;
  logic            drop_q;
  logic            mem_we_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic            if_valid_q;
  logic [31:0]     if_rdata_q;
  logic            d_valid_q;
  logic [31:0]     d_rdata_q;

  logic            if_elig;
  logic            d_elig;
  logic            grant_i;
  logic            grant_d;

  // A requester whose result is being returned this cycle is not eligible,
  // so a request still held high in its valid cycle is not issued twice.
  assign if_elig = if_req & ~pause & ~if_valid_q;
  assign d_elig  = d_req & ~d_valid_q;
  assign grant_i = if_elig & (~d_elig | (burst_cnt_q == BURST_MAX));
  assign grant_d = d_elig & ~grant_i;

  // Burst count after a data grant: counts only while a fetch is waiting.
  always_comb begin
    burst_cnt_d = '0;
    if (if_req) begin
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + BW'(1);
    end
  end

  // Arbitration FSM with registered memory-port and return-path outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q     <= BUSY_I;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            burst_cnt_q <= '0;
          end else if (grant_d) begin
            state_q     <= BUSY_D;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            burst_cnt_q <= burst_cnt_d;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            if (!(drop_q || flush)) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            d_valid_q <= 1'b1;
            d_rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded bench for mem_port_arbiter with a
// latency-programmable memory responder.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        pause;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] fq[$];
  logic [31:0] dq[$];
  int if_left = 0;
  int d_left  = 0;
  int resp_cnt = 0;
  int ack_lat  = 2;
  bit resp_en  = 1'b1;

  mem_port_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .pause(pause), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: observe returns against the scoreboard, then update the responder.
  task automatic tick();
    @(posedge clk);
    #1;
    if (if_valid) begin
      if (fq.size() == 0) check("if_unexpected", 32'(if_valid), 32'd0);
      else begin
        check("if_rdata", if_rdata, fq.pop_front());
        if_left--;
        if (if_left <= 0) if_req = 1'b0;
      end
    end
    if (d_valid) begin
      if (dq.size() == 0) check("d_unexpected", 32'(d_valid), 32'd0);
      else begin
        check("d_rdata", d_rdata, dq.pop_front());
        d_left--;
        if (d_left <= 0) d_req = 1'b0;
      end
    end
    if (resp_en) begin
      if (mem_req) begin
        resp_cnt++;
        mem_ack = (resp_cnt == ack_lat + 1);
      end else begin
        resp_cnt = 0;
        mem_ack  = 1'b0;
      end
      mem_rdata = mem_model(mem_addr);
    end
  endtask

  task automatic start_fetch(input logic [31:0] a, input int n);
    if_req  = 1'b1;
    if_addr = a;
    if_left = n;
    for (int i = 0; i < n; i++) fq.push_back(mem_model(a));
  endtask

  task automatic start_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input int n);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_left  = n;
    for (int i = 0; i < n; i++) dq.push_back(mem_model(a));
  endtask

  task automatic wait_empty(input bit want_f, input bit want_d);
    int budget;
    budget = 400;
    while (((want_f && fq.size() != 0) || (want_d && dq.size() != 0)) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; pause = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_valids", 32'({if_valid, d_valid}), 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // Fetch only, two back-to-back fetches from a held request.
    start_fetch(32'h100, 2);
    tick();
    check("f_mem_req_c1", 32'(mem_req), 32'd1);
    check("f_mem_we", 32'(mem_we), 32'd0);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_stall_if", 32'(stall_if), 32'd1);
    tick();
    check("f_mem_req_c2", 32'(mem_req), 32'd1);
    tick();
    check("f_mem_req_c3", 32'(mem_req), 32'd1);
    tick();
    check("f_valid_c4", 32'(if_valid), 32'd1);
    check("f_stall_if_c4", 32'(stall_if), 32'd0);
    check("f_mem_req_c4", 32'(mem_req), 32'd0);
    tick();
    check("f_no_regrant", 32'(mem_req), 32'd0);
    tick();
    check("f_regrant", 32'(mem_req), 32'd1);
    wait_empty(1'b1, 1'b1);
    repeat (2) tick();

    // Simultaneous store and fetch: data first, fetch in the d_valid cycle.
    start_fetch(32'h300, 1);
    start_data(1'b1, 32'h200, 32'hDEAD_BEEF, 1);
    tick();
    check("s_mem_we", 32'(mem_we), 32'd1);
    check("s_mem_addr", mem_addr, 32'h200);
    check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_stalls", 32'({stall_if, stall_mem}), 32'd3);
    repeat (3) tick();
    check("s_d_valid", 32'(d_valid), 32'd1);
    tick();
    check("s_f_grant", 32'(mem_req), 32'd1);
    check("s_f_addr", mem_addr, 32'h300);
    check("s_f_we", 32'(mem_we), 32'd0);
    wait_empty(1'b1, 1'b1);
    repeat (2) tick();

    // Burst below the limit: three paused data grants, data still wins.
    pause = 1'b1;
    start_fetch(32'h400, 1);
    start_data(1'b0, 32'h500, 32'h0, 3);
    wait_empty(1'b0, 1'b1);
    tick();
    check("b3_paused_idle", 32'(mem_req), 32'd0);
    pause = 1'b0;
    start_data(1'b0, 32'h600, 32'h0, 1);
    tick();
    check("b3_data_first", mem_addr, 32'h600);
    wait_empty(1'b1, 1'b1);
    repeat (2) tick();

    // Burst at the (saturated) limit: the waiting fetch wins over data.
    pause = 1'b1;
    start_fetch(32'h700, 1);
    start_data(1'b0, 32'h800, 32'h0, 5);
    wait_empty(1'b0, 1'b1);
    tick();
    pause = 1'b0;
    start_data(1'b0, 32'h900, 32'h0, 1);
    tick();
    check("b4_fetch_first", mem_addr, 32'h700);
    wait_empty(1'b1, 1'b0);
    tick();
    check("b4_then_data", mem_addr, 32'h900);
    wait_empty(1'b1, 1'b1);
    repeat (2) tick();

    // Flush one cycle into BUSY_I.
    start_fetch(32'hA00, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    check("fl_dropped", 32'(if_valid), 32'd0);
    tick();
    check("fl_refetch", 32'(mem_req), 32'd1);
    check("fl_refetch_addr", mem_addr, 32'hA00);
    wait_empty(1'b1, 1'b1);
    repeat (2) tick();

    // Flush in the mem_ack cycle of BUSY_I.
    start_fetch(32'hB00, 1);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fla_dropped", 32'(if_valid), 32'd0);
    wait_empty(1'b1, 1'b1);
    repeat (2) tick();

    // Flush does not affect a data transaction.
    flush = 1'b1;
    start_data(1'b1, 32'hF00, 32'h1234_5678, 1);
    wait_empty(1'b0, 1'b1);
    flush = 1'b0;
    repeat (2) tick();

    // Pause blocks the fetch grant; pause during BUSY_I does not abort it.
    pause = 1'b1;
    start_fetch(32'hC00, 1);
    repeat (3) tick();
    check("p_no_grant", 32'(mem_req), 32'd0);
    check("p_stall_if", 32'(stall_if), 32'd1);
    pause = 1'b0;
    tick();
    check("p_grant", 32'(mem_req), 32'd1);
    check("p_grant_addr", mem_addr, 32'hC00);
    pause = 1'b1;
    wait_empty(1'b1, 1'b0);
    pause = 1'b0;
    repeat (2) tick();

    // Requester inputs dropped/changed mid-transaction; port stays stable.
    start_data(1'b0, 32'hD00, 32'h0, 1);
    tick();
    d_req  = 1'b0;
    d_addr = 32'hEEE;
    tick();
    check("h_mem_req", 32'(mem_req), 32'd1);
    check("h_mem_addr", mem_addr, 32'hD00);
    wait_empty(1'b0, 1'b1);
    repeat (2) tick();

    // Stray mem_ack while idle.
    resp_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    tick();
    check("st_mem_req", 32'(mem_req), 32'd0);
    check("st_valids", 32'({if_valid, d_valid}), 32'd0);

    // Reset mid BUSY_D, then a late ack.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hE00; d_left = 0;
    tick();
    check("r_busy", 32'(mem_req), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("r_async_req", 32'(mem_req), 32'd0);
    check("r_async_addr", mem_addr, 32'd0);
    d_req = 1'b0;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("r_late_ack_valid", 32'(d_valid), 32'd0);
    check("r_late_ack_req", 32'(mem_req), 32'd0);
    tick();
    check("r_no_valid", 32'(d_valid), 32'd0);

    check("fq_drained", 32'(fq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
